// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared opcodes, latency defaults and FSM states for the mult/div unit
//
// Purpose : common definitions imported by muldiv_arith and muldiv_ctrl.
// Contents: op_t operation codes, default latencies, state_t FSM encoding.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_t;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/muldiv_arith.sv
// rtl/muldiv_arith.sv - combinational 64-bit product / quotient-remainder generator
//
// Purpose : computes the HI/LO pair an arithmetic op will leave behind.
// Ports   : op            operation code (op_t encoding)
//           a, b          rs and rt operands
//           old_hi/old_lo current architectural HI/LO (held on divide by zero)
//           res_hi/res_lo resulting HI/LO
module muldiv_arith
    import muldiv_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] old_hi,
    input  logic [31:0] old_lo,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] mag_q;
    logic [31:0] mag_r;
    logic [31:0] sgn_q;
    logic [31:0] sgn_r;
    logic [31:0] uns_q;
    logic [31:0] uns_r;
    logic        div_zero;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide runs on magnitudes and fixes signs afterwards. The
    // magnitude of 0x80000000 is still 0x80000000 as an unsigned value, so
    // 0x80000000 / -1 naturally yields quotient 0x80000000, remainder 0.
    assign abs_a = a[31] ? (~a + 32'd1) : a;
    assign abs_b = b[31] ? (~b + 32'd1) : b;
    assign div_zero = (b == 32'd0);

    assign mag_q = div_zero ? 32'd0 : abs_a / abs_b;
    assign mag_r = div_zero ? 32'd0 : abs_a % abs_b;
    assign uns_q = div_zero ? 32'd0 : a / b;
    assign uns_r = div_zero ? 32'd0 : a % b;

    // Quotient truncates toward zero; remainder follows the dividend's sign.
    assign sgn_q = (a[31] ^ b[31]) ? (~mag_q + 32'd1) : mag_q;
    assign sgn_r = a[31] ? (~mag_r + 32'd1) : mag_r;

    always_comb begin
        res_hi = old_hi;
        res_lo = old_lo;
        case (op)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV: begin
                if (!div_zero) begin
                    res_hi = sgn_r;
                    res_lo = sgn_q;
                end
            end
            OP_DIVU: begin
                if (!div_zero) begin
                    res_hi = uns_r;
                    res_lo = uns_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - multi-cycle mult/div sequencer owning the HI/LO registers
//
// Purpose : accepts MULT/MULTU/DIV/DIVU (start) and MTHI/MTLO (hilo_wr),
//           holds busy for the fixed op latency, then commits HI/LO.
// Ports   : clk, reset (async, active-high)
//           start, hilo_wr, op, rs_val, rt_val   E-stage operation
//           busy                                 op in flight
//           hi, lo                               architectural HI/LO
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        hilo_wr,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] p_hi;
    logic [31:0] p_lo;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        is_mul;
    logic        is_div;

    muldiv_arith u_arith (
        .op     (op),
        .a      (rs_val),
        .b      (rt_val),
        .old_hi (hi),
        .old_lo (lo),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div = (op == OP_DIV)  || (op == OP_DIVU);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
            p_hi  <= 32'd0;
            p_lo  <= 32'd0;
            busy  <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // start outranks hilo_wr; a start with a non-arithmetic
                    // op is dropped rather than falling through to MTHI/MTLO.
                    if (start) begin
                        if (is_mul || is_div) begin
                            p_hi  <= res_hi;
                            p_lo  <= res_lo;
                            cnt   <= is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                            busy  <= 1'b1;
                            state <= ST_RUN;
                        end
                    end else if (hilo_wr) begin
                        if (op == OP_MTHI) begin
                            hi <= rs_val;
                        end else if (op == OP_MTLO) begin
                            lo <= rs_val;
                        end
                    end
                end
                ST_RUN: begin
                    // New requests are ignored here; the hazard unit stalls them.
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        hi    <= p_hi;
                        lo    <= p_lo;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - self-checking bench for muldiv_ctrl against a transaction-level model
module tb_muldiv_ctrl;

    localparam int NMUL = 5;
    localparam int NDIV = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        hilo_wr = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;

    muldiv_ctrl #(.MULT_CYCLES(NMUL), .DIV_CYCLES(NDIV)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .hilo_wr (hilo_wr),
        .op      (op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic from the architectural definition, using 64-bit
    // signed arithmetic so that 0x80000000 / -1 does not overflow.
    function automatic logic [63:0] ref_calc(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] oh,
                                             input logic [31:0] ol);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = {oh, ol};
        case (o)
            3'd0: res = 64'(sa * sb);
            3'd1: res = {32'd0, a} * {32'd0, b};
            3'd2: if (b != 32'd0) begin
                q = sa / sb;
                r = sa % sb;
                res = {r[31:0], q[31:0]};
            end
            3'd3: if (b != 32'd0) res = {a % b, a / b};
            default: ;
        endcase
        return res;
    endfunction

    // Transaction-level model: remaining busy cycles plus pending result.
    int          m_left = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [63:0] m_pend = 64'd0;
    logic        chk_en = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left <= 0;
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
            m_pend <= 64'd0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_hi <= m_pend[63:32];
                m_lo <= m_pend[31:0];
            end
        end else if (start) begin
            if (op <= 3'd3) begin
                m_pend <= ref_calc(op, rs_val, rt_val, m_hi, m_lo);
                m_left <= (op <= 3'd1) ? NMUL : NDIV;
            end
        end else if (hilo_wr) begin
            if (op == 3'd4) m_hi <= rs_val;
            if (op == 3'd5) m_lo <= rs_val;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_busy", {31'd0, busy}, {31'd0, (m_left > 0)});
            check("model_hi", hi, m_hi);
            check("model_lo", lo, m_lo);
        end
    end

    // Present one cycle of request, return #1 after the edge that sampled it.
    task automatic req(input logic [2:0] o, input logic s, input logic hw,
                       input logic [31:0] a, input logic [31:0] b);
        op = o; start = s; hilo_wr = hw; rs_val = a; rt_val = b;
        @(posedge clk); #1;
        start = 0; hilo_wr = 0;
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int exp_n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        req(o, 1'b1, 1'b0, a, b);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        check({name, "_busy_cycles"}, 32'(n), 32'(exp_n));
        check({name, "_hi"}, hi, exp_hi);
        check({name, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        #1 reset = 1'b1;
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        run_op("mult", 3'd0, 32'hFFFFFFFD, 32'd5, 5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("multu", 3'd1, 32'hFFFFFFFD, 32'd5, 5, 32'h00000004, 32'hFFFFFFF1);
        run_op("div", 3'd2, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu", 3'd3, 32'd7, 32'd2, 10, 32'd1, 32'd3);

        req(3'd4, 1'b0, 1'b1, 32'h12345678, 32'd0);
        check("mthi_hi", hi, 32'h12345678);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        run_op("div0", 3'd2, 32'd99, 32'd0, 10, 32'h12345678, 32'd3);
        run_op("divovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000);
        req(3'd5, 1'b1, 1'b1, 32'hAAAA5555, 32'd0);
        check("start_wins_lo", lo, 32'h80000000);
        check("start_undef_busy", {31'd0, busy}, 32'd0);

        // Requests while busy are ignored; the first one at T+6 is accepted.
        req(3'd0, 1'b1, 1'b0, 32'd6, 32'd7);
        start = 1'b1; op = 3'd3; rs_val = 32'd100; rt_val = 32'd3;
        for (int i = 1; i <= 5; i++) begin
            check("ignore_busy", {31'd0, busy}, 32'd1);
            @(posedge clk); #1;
        end
        op = 3'd1; rs_val = 32'hFFFFFFFF; rt_val = 32'd2;
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_hi", hi, 32'd0);
        check("t6_lo", lo, 32'd42);
        @(posedge clk); #1;
        start = 1'b0;
        check("t7_busy", {31'd0, busy}, 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("b2b_hi", hi, 32'd1);
        check("b2b_lo", lo, 32'hFFFFFFFE);

        // Asynchronous reset in the middle of a divide.
        req(3'd3, 1'b1, 1'b0, 32'd1000, 32'd7);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #3 reset = 1'b1;
        #1;
        check("areset_busy", {31'd0, busy}, 32'd0);
        check("areset_hi", hi, 32'd0);
        check("areset_lo", lo, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("post_reset_busy", {31'd0, busy}, 32'd0);
        check("post_reset_hi", hi, 32'd0);
        check("post_reset_lo", lo, 32'd0);

        // Random traffic, including protocol violations and rare resets.
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = 32'(int'($urandom_range(1, 9)));
                default: ;
            endcase
            op = 3'($urandom_range(0, 7));
            start = ($urandom_range(0, 3) == 0);
            hilo_wr = ($urandom_range(0, 3) == 0);
            rs_val = a;
            rt_val = b;
            if ($urandom_range(0, 299) == 0) begin
                #2 reset = 1'b1;
                #2 reset = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 0;
        hilo_wr = 0;
        repeat (12) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
